// File: rtl/uart_tx_fifo_reader.sv
// UART transmitter that pulls words from an async FIFO read port and serialises
// them as start / LSB-first data / optional parity / stop frames, back-to-back when data is waiting.
`timescale 1ns/1ps

module uart_tx_fifo_reader #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  FIFO_EMPTY,
  input  logic [DATA_WIDTH-1:0] FIFO_RD_DATA,
  output logic                  FIFO_RD_INC,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  BUSY
);

  localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [CNT_W-1:0]      bit_cnt;
  logic                  par_en_q;
  logic                  par_bit_q;
  logic                  pop;

  // Pop only from IDLE or the final stop cycle, so at most one word per frame;
  // gated by reset so the strobe is low while the block is held in reset.
  assign pop         = RST && ((state == IDLE) || (state == STOP)) && !FIFO_EMPTY;
  assign FIFO_RD_INC = pop;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      shift_q   <= '0;
      bit_cnt   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      TX_OUT    <= 1'b1;
      BUSY      <= 1'b0;
    end else if (pop) begin
      // Capture word and line config once; they stay frozen for the frame
      shift_q   <= FIFO_RD_DATA;
      par_en_q  <= PAR_EN;
      par_bit_q <= (^FIFO_RD_DATA) ^ PAR_TYP;
      bit_cnt   <= '0;
      TX_OUT    <= 1'b0;
      BUSY      <= 1'b1;
      state     <= START;
    end else begin
      case (state)
        IDLE: begin
          TX_OUT <= 1'b1;
          BUSY   <= 1'b0;
        end
        START: begin
          TX_OUT  <= shift_q[0];
          shift_q <= shift_q >> 1;
          bit_cnt <= '0;
          state   <= DATA;
        end
        DATA: begin
          if (bit_cnt == CNT_W'(DATA_WIDTH - 1)) begin
            if (par_en_q) begin
              TX_OUT <= par_bit_q;
              state  <= PARITY;
            end else begin
              TX_OUT <= 1'b1;
              state  <= STOP;
            end
          end else begin
            TX_OUT  <= shift_q[0];
            shift_q <= shift_q >> 1;
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        PARITY: begin
          TX_OUT <= 1'b1;
          state  <= STOP;
        end
        STOP: begin
          TX_OUT <= 1'b1;
          BUSY   <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          TX_OUT <= 1'b1;
          BUSY   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_reader.sv
// Bench for uart_tx_fifo_reader: queue-based FIFO, frame-level line model,
// table of known frames, hand-built corner sequences and randomised traffic.
`timescale 1ns/1ps

module tb_uart_tx_fifo_reader;

  localparam int unsigned W = 8;

  logic         CLK;
  logic         RST;
  logic         FIFO_EMPTY;
  logic [W-1:0] FIFO_RD_DATA;
  logic         FIFO_RD_INC;
  logic         PAR_EN;
  logic         PAR_TYP;
  logic         TX_OUT;
  logic         BUSY;

  uart_tx_fifo_reader #(.DATA_WIDTH(W)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .FIFO_EMPTY   (FIFO_EMPTY),
    .FIFO_RD_DATA (FIFO_RD_DATA),
    .FIFO_RD_INC  (FIFO_RD_INC),
    .PAR_EN       (PAR_EN),
    .PAR_TYP      (PAR_TYP),
    .TX_OUT       (TX_OUT),
    .BUSY         (BUSY)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] fifo_q[$];   // words waiting in the FIFO
  logic         frame[$];    // line bits still to be sent, head is the current bit
  logic         last_tx, last_busy, last_rd;

  typedef struct {
    logic [W-1:0] word;
    logic         pen;
    logic         ptyp;
    int           len;
    logic [0:11]  bits;
  } vec_t;

  task automatic check(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t actual=%b required=%b", name, $time, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, exp);
    end
  endtask

  task automatic drive_fifo();
    FIFO_EMPTY   = (fifo_q.size() == 0);
    FIFO_RD_DATA = (fifo_q.size() != 0) ? fifo_q[0] : '0;
  endtask

  // One clock: compare outputs mid-cycle against the model, then advance both
  task automatic step();
    logic         exp_tx, exp_busy, exp_rd, dut_pop, pen, ptyp;
    logic [W-1:0] head;
    @(negedge CLK);
    exp_busy = (frame.size() > 0);
    exp_tx   = exp_busy ? frame[0] : 1'b1;
    exp_rd   = (frame.size() <= 1) && (fifo_q.size() > 0);
    check("tx_out", TX_OUT, exp_tx);
    check("busy", BUSY, exp_busy);
    check("rd_inc", FIFO_RD_INC, exp_rd);
    last_tx   = TX_OUT;
    last_busy = BUSY;
    last_rd   = FIFO_RD_INC;
    dut_pop   = FIFO_RD_INC;
    head      = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    pen       = PAR_EN;
    ptyp      = PAR_TYP;
    @(posedge CLK);
    if (exp_rd) begin
      frame.delete();
      frame.push_back(1'b0);
      for (int i = 0; i < int'(W); i++) frame.push_back(head[i]);
      if (pen) frame.push_back((^head) ^ ptyp);
      frame.push_back(1'b1);
    end else if (frame.size() > 0) begin
      void'(frame.pop_front());
    end
    if (dut_pop && fifo_q.size() > 0) void'(fifo_q.pop_front());
    #1;
    drive_fifo();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((frame.size() != 0 || fifo_q.size() != 0) && n < 200) begin
      step();
      n++;
    end
    check_int("idle_timeout", (n < 200) ? 1 : 0, 1);
  endtask

  // Expects a pop on the next cycle, then the listed line bits
  task automatic expect_frame(input string name, input logic [0:11] bits, input int len);
    step();
    check({name, "_pop"}, last_rd, 1'b1);
    for (int i = 0; i < len; i++) begin
      step();
      check({name, "_bit"}, last_tx, bits[i]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t actual=running required=finished", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    int   pops[$];
    int   busy_lo;
    logic [0:11] tx_seen;

    vecs[0] = '{word: 8'hA5, pen: 1'b0, ptyp: 1'b0, len: 10, bits: 12'b0101_0010_1100};
    vecs[1] = '{word: 8'h03, pen: 1'b1, ptyp: 1'b0, len: 11, bits: 12'b0110_0000_0010};
    vecs[2] = '{word: 8'h03, pen: 1'b1, ptyp: 1'b1, len: 11, bits: 12'b0110_0000_0110};
    vecs[3] = '{word: 8'h81, pen: 1'b0, ptyp: 1'b0, len: 10, bits: 12'b0100_0000_1100};
    vecs[4] = '{word: 8'hFF, pen: 1'b1, ptyp: 1'b1, len: 11, bits: 12'b0111_1111_1110};

    CLK = 1'b0; RST = 1'b0; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    drive_fifo();
    #12;
    check("rst_tx", TX_OUT, 1'b1);
    check("rst_busy", BUSY, 1'b0);
    check("rst_rd", FIFO_RD_INC, 1'b0);
    @(posedge CLK); #1 RST = 1'b1;
    repeat (3) step();

    // Known frames, one at a time
    for (int v = 0; v < 5; v++) begin
      wait_idle();
      PAR_EN  = vecs[v].pen;
      PAR_TYP = vecs[v].ptyp;
      fifo_q.push_back(vecs[v].word);
      drive_fifo();
      expect_frame("vec", vecs[v].bits, vecs[v].len);
      step();
      check("vec_idle_busy", last_busy, 1'b0);
      check("vec_idle_tx", last_tx, 1'b1);
    end

    // Empty FIFO for 50 cycles
    wait_idle();
    repeat (50) step();

    // Back-to-back 0x55, 0x0F, 0xFF without parity
    PAR_EN = 1'b0;
    fifo_q.push_back(8'h55); fifo_q.push_back(8'h0F); fifo_q.push_back(8'hFF);
    drive_fifo();
    pops.delete();
    busy_lo = 0;
    for (int k = 0; k < 32; k++) begin
      step();
      if (last_rd) pops.push_back(k);
      if (k >= 1 && k <= 30 && !last_busy) busy_lo++;
    end
    check_int("b2b_pops", pops.size(), 3);
    if (pops.size() == 3) begin
      check_int("b2b_gap1", pops[1] - pops[0], 10);
      check_int("b2b_gap2", pops[2] - pops[1], 10);
    end
    check_int("b2b_busy_drop", busy_lo, 0);
    check("b2b_end_busy", last_busy, 1'b0);

    // Parity enabled mid-frame only affects the following word
    wait_idle();
    PAR_EN = 1'b0; PAR_TYP = 1'b0;
    fifo_q.push_back(8'h81); fifo_q.push_back(8'h81);
    drive_fifo();
    pops.delete();
    for (int k = 0; k < 24; k++) begin
      if (k == 4) PAR_EN = 1'b1;
      step();
      if (last_rd) pops.push_back(k);
      if (k == 20) check("cfg_parity_bit", last_tx, 1'b0);
      if (k == 21) check("cfg_stop_bit", last_tx, 1'b1);
    end
    check_int("cfg_pops", pops.size(), 2);
    if (pops.size() == 2) check_int("cfg_gap", pops[1] - pops[0], 10);

    // Reset during data bit 3 of 0xC3, then a clean 0x3C frame
    wait_idle();
    PAR_EN = 1'b0;
    fifo_q.push_back(8'hC3); fifo_q.push_back(8'h3C);
    drive_fifo();
    repeat (5) step();
    #2;
    check("pre_rst_bit3", TX_OUT, 1'b0);
    RST = 1'b0;
    #1;
    frame.delete();
    check("arst_tx", TX_OUT, 1'b1);
    check("arst_busy", BUSY, 1'b0);
    check("arst_rd", FIFO_RD_INC, 1'b0);
    @(negedge CLK);
    check("rst_hold_tx", TX_OUT, 1'b1);
    check("rst_hold_rd", FIFO_RD_INC, 1'b0);
    @(posedge CLK); #1 RST = 1'b1;
    check_int("rst_fifo_left", fifo_q.size(), 1);
    expect_frame("rst_3c", 12'b0001_1110_0100, 10);
    step();
    check("rst_3c_idle", last_busy, 1'b0);

    // Randomised traffic and config against the line model
    for (int k = 0; k < 600; k++) begin
      if (fifo_q.size() < 3 && $urandom_range(0, 6) == 0) begin
        fifo_q.push_back(W'($urandom));
        drive_fifo();
      end
      if ($urandom_range(0, 15) == 0) PAR_EN = ~PAR_EN;
      if ($urandom_range(0, 15) == 0) PAR_TYP = ~PAR_TYP;
      step();
    end
    wait_idle();
    step();
    tx_seen = '0;
    check("final_idle_tx", last_tx, 1'b1);
    check_int("final_tx_seen", int'(tx_seen), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
